// File: rtl/packet_snooper_pkg.sv
// Shared types and constants for the packet snooper: FSM state encoding and word byte count.
package packet_snooper_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 4;

endpackage : packet_snooper_pkg

// File: rtl/packet_snooper.sv
// Streams one granted packet into a packet RAM, swallowing overflow, and reports its byte length.
// Optional PACKET_SNOOPER_TKEEP_EN adds s_tkeep so the final beat may be partially filled.
module packet_snooper
  import packet_snooper_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = BYTES_PER_WORD * 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic                    s_tvalid,
  input  logic                    s_tlast,
`ifdef PACKET_SNOOPER_TKEEP_EN
  input  logic [DATA_WIDTH/8-1:0] s_tkeep,
`endif
  output logic                    s_tready,
  input  logic                    buf_grant,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    wr_en,
  output logic                    len_rst,
  output logic                    done,
  output logic [31:0]             pkt_len,
  output logic                    trunc
);

  localparam logic [31:0]           WORD_BYTES = 32'(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    len_rst_q, len_rst_d;
  logic                    trunc_q, trunc_d;
  logic [31:0]             pkt_len_q, pkt_len_d;
  logic [31:0]             len_acc_q, len_acc_d;
  logic [31:0]             beat_bytes;
  logic [31:0]             beat_len;

`ifdef PACKET_SNOOPER_TKEEP_EN
  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < int'(DATA_WIDTH / 8); i++) begin
      beat_bytes = beat_bytes + 32'(s_tkeep[i]);
    end
  end
`else
  assign beat_bytes = WORD_BYTES;
`endif

  // Length if the current beat were the last stored one: full words before it plus its own bytes.
  assign beat_len = 32'(cnt_q) * WORD_BYTES + beat_bytes;

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    len_rst_d = 1'b0;
    trunc_d   = trunc_q;
    pkt_len_d = pkt_len_q;
    len_acc_d = len_acc_q;
    s_tready  = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (buf_grant) begin
          state_d   = WRITE;
          cnt_d     = '0;
          len_rst_d = 1'b1;
          trunc_d   = 1'b0;
          pkt_len_d = '0;
        end
      end

      WRITE: begin
        s_tready = 1'b1;
        if (s_tvalid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q;
          wr_data_d = s_tdata;
          len_acc_d = beat_len;
          if (s_tlast) begin
            state_d   = DONE;
            pkt_len_d = beat_len;
          end else if (cnt_q == LAST_ADDR) begin
            state_d = DRAIN;
            trunc_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      // RAM is full: keep the stream moving but report only what was stored.
      DRAIN: begin
        s_tready = 1'b1;
        if (s_tvalid && s_tlast) begin
          state_d   = DONE;
          pkt_len_d = len_acc_q;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      len_rst_q <= 1'b0;
      trunc_q   <= 1'b0;
      pkt_len_q <= '0;
      len_acc_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      len_rst_q <= len_rst_d;
      trunc_q   <= trunc_d;
      pkt_len_q <= pkt_len_d;
      len_acc_q <= len_acc_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign len_rst = len_rst_q;
  assign trunc   = trunc_q;
  assign pkt_len = pkt_len_q;

endmodule : packet_snooper

// File: doc/packet_snooper.md
PACKET_SNOOPER -- requirements
Module: packet_snooper

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, packet RAM word-address width (depth 2**ADDR_WIDTH words).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, stream and RAM word width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port s_tdata  input  DATA_WIDTH  inbound packet word.
REQ-006 SHALL have port s_tvalid  input  1  inbound word valid.
REQ-007 SHALL have port s_tlast  input  1  last word of packet.
REQ-008 SHALL have port s_tready  output  1  snooper accepts a word this cycle.
REQ-009 SHALL have port buf_grant  input  1  one-cycle pulse: packet RAM is free to fill.
REQ-010 SHALL have port wr_addr  output  ADDR_WIDTH  RAM write address (drives addra).
REQ-011 SHALL have port wr_data  output  DATA_WIDTH  RAM write data (drives dia).
REQ-012 SHALL have port wr_en  output  1  RAM write strobe.
REQ-013 SHALL have port len_rst  output  1  one-cycle pulse clearing the RAM length tracker.
REQ-014 SHALL have port done  output  1  one-cycle pulse: packet complete in RAM.
REQ-015 SHALL have port pkt_len  output  32  packet length in bytes, valid from done until next grant.
REQ-016 SHALL have port trunc  output  1  last packet exceeded RAM depth; held like pkt_len.

Function
REQ-017 SHALL implement states IDLE, WRITE, DRAIN, DONE.
REQ-018 IDLE: s_tready=0; buf_grant=1 -> WRITE, word counter=0, len_rst=1 next cycle, trunc cleared.
REQ-019 WRITE: s_tready=1; each beat (s_tvalid&s_tready) registers wr_en=1, wr_addr=counter, wr_data=s_tdata one cycle later.
REQ-020 WRITE beat with s_tlast=1 -> DONE; else beat at counter==2**ADDR_WIDTH-1 -> DRAIN with trunc=1; else counter+1.
REQ-021 DRAIN: s_tready=1, beats discarded (wr_en=0); beat with s_tlast -> DONE.
REQ-022 DONE: done=1 for exactly one cycle, s_tready=0 -> IDLE; buf_grant ignored outside IDLE.
REQ-023 pkt_len SHALL equal stored words*4 (excluding DRAIN beats), updated on the DONE-entry beat.
REQ-024 wr_en SHALL be 0 in every cycle without a WRITE-state beat; s_tvalid=0 cycles stall without state change.
REQ-025 Single-word packet (tlast on first beat) SHALL write addr 0 and report pkt_len=4.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE; s_tready, wr_en, len_rst, done, trunc=0; wr_addr, wr_data, pkt_len=0.
REQ-027 Reset mid-packet SHALL abandon the packet without done; remaining beats wait for the next grant.

Configuration
REQ-028 Macro PACKET_SNOOPER_TKEEP_EN defined: SHALL add input s_tkeep (DATA_WIDTH/8, contiguous from MSB byte) and pkt_len = full words*4 + popcount(tkeep) of last stored beat.
REQ-029 Macro undefined: no s_tkeep port; every word counts as DATA_WIDTH/8 bytes.

Structure
REQ-030 Package packet_snooper_pkg SHALL hold the state enum and BYTES_PER_WORD constant.
REQ-031 No sub-module; FSM, counter and length logic SHALL be in one module.

Verification
REQ-032 Grant, 3-word packet 0xA,0xB,0xC with tlast on 3rd -> wr at addr 0,1,2, done once, pkt_len=12, trunc=0.
REQ-033 ADDR_WIDTH=2, 6-word packet -> writes addr 0..3 only, DRAIN swallows 2 words, pkt_len=16, trunc=1.
REQ-034 Valid words without grant -> s_tready=0, wr_en=0 for 20 cycles; grant pulse -> len_rst next cycle, then accept.
REQ-035 rst_n low after 2 of 5 words -> outputs zero immediately, no done; new grant restarts at addr 0.
REQ-036 PACKET_SNOOPER_TKEEP_EN, 2 words, last tkeep=4'b1100 -> pkt_len=6.
